// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - RV32 ALU opcodes and the sequential multiplier state type
package alu_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_LT  = 4'b0111;
  localparam logic [3:0] ALU_SRL = 4'b1000;
  localparam logic [3:0] ALU_SLL = 4'b1001;
  localparam logic [3:0] ALU_SRA = 4'b1010;
  localparam logic [3:0] ALU_XOR = 4'b1101;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADD,
    S_SLL,
    S_SRL,
    S_DONE
  } mul_state_t;

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - combinational RV32 ALU
module alu
  import alu_pkg::*;
(
  input  logic [31:0] op1,
  input  logic [31:0] op2,
  input  logic [3:0]  alu_op,
  output logic [31:0] result,
  output logic        zero
);

  always_comb begin
    result = '0;
    case (alu_op)
      ALU_AND: result = op1 & op2;
      ALU_OR:  result = op1 | op2;
      ALU_ADD: result = op1 + op2;
      ALU_SUB: result = op1 - op2;
      ALU_LT:  result = {31'b0, ($signed(op1) < $signed(op2))};
      ALU_SRL: result = op1 >> op2[4:0];
      ALU_SLL: result = op1 << op2[4:0];
      ALU_SRA: result = $unsigned($signed(op1) >>> op2[4:0]);
      ALU_XOR: result = op1 ^ op2;
      default: result = '0;
    endcase
  end

  assign zero = (result == 32'd0);

endmodule

// File: rtl/alu_mul_seq.sv
// rtl/alu_mul_seq.sv - shift-and-add 32-bit multiplier sequenced over one shared ALU
module alu_mul_seq
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic        busy,
  output logic        done,
  output logic [31:0] product
);

  mul_state_t  state, state_next;
  logic [31:0] mcand, mplier, prod;
  logic [31:0] op1, op2, result;
  logic [3:0]  alu_op;
  logic        zero;

  alu u_alu (
    .op1    (op1),
    .op2    (op2),
    .alu_op (alu_op),
    .result (result),
    .zero   (zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    op1        = '0;
    op2        = '0;
    alu_op     = ALU_ADD;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (op_b == 32'd0)  state_next = S_DONE;
          else if (op_b[0])   state_next = S_ADD;
          else                state_next = S_SLL;
        end
      end
      S_ADD: begin
        op1        = prod;
        op2        = mcand;
        alu_op     = ALU_ADD;
        state_next = S_SLL;
      end
      S_SLL: begin
        op1        = mcand;
        op2        = 32'd1;
        alu_op     = ALU_SLL;
        state_next = S_SRL;
      end
      S_SRL: begin
        op1    = mplier;
        op2    = 32'd1;
        alu_op = ALU_SRL;
        // Stop as soon as no multiplier bits remain.
        if (zero)           state_next = S_DONE;
        else if (result[0]) state_next = S_ADD;
        else                state_next = S_SLL;
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= '0;
      mplier <= '0;
      prod   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            mcand  <= op_a;
            mplier <= op_b;
            prod   <= '0;
          end
        end
        S_ADD:   prod   <= result;
        S_SLL:   mcand  <= result;
        S_SRL:   mplier <= result;
        default: ;
      endcase
    end
  end

  assign busy    = (state != S_IDLE);
  assign done    = (state == S_DONE);
  assign product = prod;

endmodule

// File: tb/tb_alu_mul_seq.sv
// tb/tb_alu_mul_seq.sv - directed and random checks of alu_mul_seq
module tb_alu_mul_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        busy;
  logic        done;
  logic [31:0] product;

  int n_assert = 0;
  int n_fail   = 0;

  alu_mul_seq dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .op_a    (op_a),
    .op_b    (op_b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic int exp_latency(input logic [31:0] b);
    int msb, pop;
    msb = -1;
    pop = 0;
    for (int i = 0; i < 32; i++) begin
      if (b[i]) begin
        msb = i;
        pop++;
      end
    end
    if (b == 32'd0) return 1;
    return 2 * (msb + 1) + pop + 1;
  endfunction

  // Leaves the bench sampling cycle 1 (#1 after the accepting edge), start still high.
  task automatic launch(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    op_a  = a;
    op_b  = b;
    start = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Entered at cycle 1; returns in the cycle after done.
  task automatic wait_done(input string tag, input logic [31:0] exp_p, input int exp_n);
    int c;
    int busy_low;
    logic got;
    c = 1;
    busy_low = 0;
    got = 1'b0;
    while (c <= 120 && !got) begin
      if (!busy) busy_low++;
      if (done) got = 1'b1;
      else begin
        @(posedge clk);
        #1;
        c++;
      end
    end
    check({tag, " done_seen"}, {31'b0, got}, 32'd1);
    check({tag, " latency"}, c, exp_n);
    check({tag, " product"}, product, exp_p);
    check({tag, " busy_during_op"}, busy_low, 32'd0);
    @(posedge clk);
    #1;
    check({tag, " busy_after"}, {31'b0, busy}, 32'd0);
    check({tag, " done_after"}, {31'b0, done}, 32'd0);
  endtask

  initial begin
    int done_cnt;
    logic [31:0] ra, rb, rp;

    // Reset held for three cycles.
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset busy", {31'b0, busy}, 32'd0);
    check("reset done", {31'b0, done}, 32'd0);
    check("reset product", product, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    done_cnt = 0;
    repeat (5) begin
      @(posedge clk);
      #1;
      if (done) done_cnt++;
    end
    check("idle no done", done_cnt, 32'd0);
    check("idle busy", {31'b0, busy}, 32'd0);

    launch(32'd3, 32'd5);
    start = 1'b0;
    wait_done("3x5", 32'd15, 9);

    launch(32'd7, 32'd0);
    start = 1'b0;
    wait_done("7x0", 32'd0, 1);

    launch(32'd0, 32'h12345678);
    start = 1'b0;
    wait_done("0x12345678", 32'd0, 72);

    launch(32'hFFFFFFFF, 32'hFFFFFFFF);
    start = 1'b0;
    wait_done("ffxff", 32'h00000001, 97);

    launch(32'h80000000, 32'd2);
    start = 1'b0;
    wait_done("80000000x2", 32'h00000000, 6);

    // Start held high with new operands throughout a busy operation.
    launch(32'd3, 32'd5);
    op_a = 32'd9;
    op_b = 32'd9;
    wait_done("held first", 32'd15, 9);
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done("held second", 32'd81, 11);

    // Reset in cycle 20 of 0xFFFFFFFF x 3.
    launch(32'hFFFFFFFF, 32'd3);
    start = 1'b0;
    repeat (19) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort busy", {31'b0, busy}, 32'd0);
    check("abort done", {31'b0, done}, 32'd0);
    check("abort product", product, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    done_cnt = 0;
    repeat (110) begin
      @(posedge clk);
      #1;
      if (done) done_cnt++;
    end
    check("abort no done", done_cnt, 32'd0);

    launch(32'd6, 32'd7);
    start = 1'b0;
    wait_done("6x7", 32'd42, 2 * 3 + 3 + 1);

    // Random regression; multiplier widths vary so latencies spread.
    for (int i = 0; i < 1000; i++) begin
      ra = $urandom;
      rb = $urandom;
      rb = rb >> $urandom_range(0, 31);
      rp = ra * rb;
      launch(ra, rb);
      start = 1'b0;
      wait_done("random", rp, exp_latency(rb));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
